// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: size codes, FSM state codes,
// the response-FIFO entry layout and the delay LFSR seed.
package sram_like_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [0:0] A_IDLE = 1'b0;
  localparam logic [0:0] A_WAIT = 1'b1;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_WAIT = 2'd1;
  localparam logic [1:0] D_RESP = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } resp_entry_t;

  localparam int ENTRY_W = 33;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// Synchronous FIFO holding accepted-but-unanswered responses; push and pop
// in the same cycle are both honoured.
module sram_like_responder_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage arrays carry no reset; only the pointers and count define
  // which entries are valid, and a reset on the array would cost a port per word.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like (req/addr_ok/data_ok) responder with in-order, delayed responses.
// Define SRAM_RESP_RAND_DELAY_EN to draw delays from an LFSR instead of parameters.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int OUTSTANDING = 2,
  parameter int ADDR_DELAY  = 0,
  parameter int DATA_DELAY  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] widx;
  logic [2:0]        a_load;
  logic [2:0]        d_load;
  logic [0:0]        a_state;
  logic [2:0]        acnt;
  logic              a_ready;
  logic              hs;
  logic [1:0]        d_state;
  logic [1:0]        d_first;
  logic [2:0]        dcnt;
  logic [31:0]       rdata_q;
  resp_entry_t       push_entry;
  resp_entry_t       head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              more;
  logic              unused_inputs;

  assign widx          = addr[ADDR_W+1:2];
  assign unused_inputs = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign a_load = lfsr[2:0];
  assign d_load = lfsr[5:3];
`else
  assign a_load = 3'(ADDR_DELAY);
  assign d_load = 3'(DATA_DELAY);
`endif

  // The idle cycle in which req is first seen counts toward the address delay,
  // so addr_ok rises on the (delay+1)-th cycle of a held request.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    a_ready = 1'b0;
    if (a_state == A_IDLE) a_ready = (a_load == 3'd0);
    else                   a_ready = (acnt == 3'd0);
  end

  assign addr_ok = req & a_ready & ~full & ~reset;
  assign hs      = req & addr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_state <= A_IDLE;
      acnt    <= '0;
    end else if (a_state == A_IDLE) begin
      if (req && !hs) begin
        a_state <= A_WAIT;
        acnt    <= (a_load == 3'd0) ? 3'd0 : a_load - 3'd1;
      end
    end else if (hs || !req) begin
      a_state <= A_IDLE;
    end else if (acnt != 3'd0) begin
      acnt <= acnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs && wr) mem[widx] <= merge_bytes(mem[widx], wdata, wstrb);
  end

  always_comb begin
    push_entry.wr    = wr;
    push_entry.rdata = wr ? 32'h0 : mem[widx];
  end

  sram_like_responder_resp_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ENTRY_W)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (hs),
    .push_data (push_entry),
    .pop       (data_ok),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Lookahead on the push lets a zero-delay response follow its handshake by one cycle.
  assign more    = hs | (count > CNT_W'(1));
  assign d_first = (d_load == 3'd0) ? D_RESP : D_WAIT;
  assign data_ok = (d_state == D_RESP) & ~reset;
  assign rdata   = (data_ok && !head.wr) ? head.rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_state <= D_IDLE;
      dcnt    <= '0;
      rdata_q <= '0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (!empty || hs) begin
            d_state <= d_first;
            dcnt    <= d_load;
          end
        end
        D_WAIT: begin
          if (dcnt <= 3'd1) d_state <= D_RESP;
          else              dcnt    <= dcnt - 3'd1;
        end
        D_RESP: begin
          if (!head.wr) rdata_q <= head.rdata;
          if (more) begin
            d_state <= d_first;
            dcnt    <= d_load;
          end else begin
            d_state <= D_IDLE;
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: three responders (no delay, data delay 3, address delay 2)
// sharing request fields, each with its own req line.
module tb_sram_like_responder;
  import sram_like_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_v;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  addr_ok_v;
  logic [2:0]  data_ok_v;
  logic [31:0] rdata_v [3];

  int          checks = 0;
  int          errors = 0;
  int          dok_cnt [3] = '{0, 0, 0};
  logic [31:0] rq1 [$];

  always #5 clk = ~clk;

  sram_like_responder #(.ADDR_W(8), .OUTSTANDING(2), .ADDR_DELAY(0), .DATA_DELAY(0)) u0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]),
    .rdata(rdata_v[0]));

  sram_like_responder #(.ADDR_W(8), .OUTSTANDING(2), .ADDR_DELAY(0), .DATA_DELAY(3)) u1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]),
    .rdata(rdata_v[1]));

  sram_like_responder #(.ADDR_W(8), .OUTSTANDING(2), .ADDR_DELAY(2), .DATA_DELAY(0)) u2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok_v[2]), .data_ok(data_ok_v[2]),
    .rdata(rdata_v[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (data_ok_v[i]) dok_cnt[i]++;
    if (data_ok_v[1]) rq1.push_back(rdata_v[1]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One non-overlapped transfer on the zero-delay unit; exp_rd is the rdata
  // expected during its data_ok (the read word, or the held value for writes).
  task automatic u0_xfer(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_rd);
    @(negedge clk);
    wr = w; addr = a; wdata = d; wstrb = s; req_v[0] = 1'b1;
    #1;
    check_bit({tag, "_addr_ok"}, addr_ok_v[0], 1'b1);
    @(negedge clk);
    req_v[0] = 1'b0;
    #1;
    check_bit({tag, "_data_ok"}, data_ok_v[0], 1'b1);
    check({tag, "_rdata"}, rdata_v[0], exp_rd);
  endtask

  task automatic issue(input int u, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, output int waited);
    @(negedge clk);
    wr = w; addr = a; wdata = d; wstrb = s; req_v[u] = 1'b1;
    waited = 0;
    #1;
    while (!addr_ok_v[u] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check_bit("issue_in_budget", waited < 20, 1'b1);
    @(posedge clk);
    #1;
    req_v[u] = 1'b0;
  endtask

  task automatic wait_dok(input string tag, input int u, input int target);
    int n;
    n = 0;
    while (dok_cnt[u] < target && n < 100) begin
      step();
      n++;
    end
    check(tag, dok_cnt[u], target);
  endtask

  initial begin
    int w;
    int base;
    reset = 1'b1; req_v = 3'b111; wr = 1'b0; size = SZ_WORD;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    step();
    check_bit("rst_addr_ok0", addr_ok_v[0], 1'b0);
    check_bit("rst_addr_ok1", addr_ok_v[1], 1'b0);
    check_bit("rst_data_ok0", data_ok_v[0], 1'b0);
    check("rst_rdata0", rdata_v[0], 32'h0);
    @(negedge clk);
    reset = 1'b0; req_v = 3'b000;
    repeat (3) step();
    check("idle_no_data_ok", dok_cnt[0] + dok_cnt[1] + dok_cnt[2], 0);

    // Pipelined write then read on the zero-delay unit.
    @(negedge clk);
    wr = 1'b1; addr = 32'h1C00_0000; wdata = 32'h1234_5678; wstrb = 4'hF; req_v[0] = 1'b1;
    #1;
    check_bit("wr_addr_ok_same_cycle", addr_ok_v[0], 1'b1);
    check_bit("wr_no_early_data_ok", data_ok_v[0], 1'b0);
    @(negedge clk);
    wr = 1'b0; wstrb = 4'h0;
    #1;
    check_bit("wr_data_ok_t1", data_ok_v[0], 1'b1);
    check_bit("rd_addr_ok", addr_ok_v[0], 1'b1);
    @(negedge clk);
    req_v[0] = 1'b0;
    #1;
    check_bit("rd_data_ok_t1", data_ok_v[0], 1'b1);
    check("rd_rdata", rdata_v[0], 32'h1234_5678);
    step();
    check_bit("data_ok_single_pulse", data_ok_v[0], 1'b0);
    check("rdata_hold", rdata_v[0], 32'h1234_5678);

    // Byte strobes, no-op write, aliasing and a second word.
    u0_xfer("part_wr", 1'b1, 32'h1C00_0000, 32'hAABB_CCDD, 4'b0010, 32'h1234_5678);
    u0_xfer("part_rd", 1'b0, 32'h1C00_0000, 32'h0, 4'h0, 32'h1234_CC78);
    u0_xfer("nop_wr", 1'b1, 32'h1C00_0000, 32'hFFFF_FFFF, 4'h0, 32'h1234_CC78);
    u0_xfer("alias_rd", 1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'h1234_CC78);
    u0_xfer("w1_wr", 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 32'h1234_CC78);
    u0_xfer("w1_rd", 1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'hDEAD_BEEF);

    // Preload the data-delay unit.
    issue(1, 1'b1, 32'h10, 32'h1111_1111, 4'hF, w);
    check("u1_first_wait", w, 0);
    issue(1, 1'b1, 32'h20, 32'h2222_2222, 4'hF, w);
    issue(1, 1'b1, 32'h30, 32'h3333_3333, 4'hF, w);
    wait_dok("u1_wr_responses", 1, 3);
    step();
    rq1.delete();

    // Three back-to-back reads against a two-entry FIFO with DATA_DELAY=3.
    @(negedge clk);
    wr = 1'b0; wstrb = 4'h0; addr = 32'h10; req_v[1] = 1'b1;
    #1;
    check_bit("b2b_ok1", addr_ok_v[1], 1'b1);
    @(negedge clk);
    addr = 32'h20;
    #1;
    check_bit("b2b_ok2", addr_ok_v[1], 1'b1);
    @(negedge clk);
    addr = 32'h30;
    #1;
    check_bit("b2b_full_c2", addr_ok_v[1], 1'b0);
    step();
    check_bit("b2b_full_c3", addr_ok_v[1], 1'b0);
    check_bit("b2b_no_dok_c3", data_ok_v[1], 1'b0);
    step();
    check_bit("b2b_full_during_pop", addr_ok_v[1], 1'b0);
    check_bit("b2b_dok_c4", data_ok_v[1], 1'b1);
    check("b2b_rdata_c4", rdata_v[1], 32'h1111_1111);
    step();
    check_bit("b2b_ok3_after_pop", addr_ok_v[1], 1'b1);
    @(negedge clk);
    req_v[1] = 1'b0;
    #1;
    check_bit("b2b_dok_c6", data_ok_v[1], 1'b0);
    for (int k = 7; k <= 12; k++) begin
      step();
      check_bit($sformatf("b2b_dok_c%0d", k), data_ok_v[1], (k == 8) || (k == 12));
    end
    check("b2b_resp_count", rq1.size(), 3);
    check("b2b_order0", rq1[0], 32'h1111_1111);
    check("b2b_order1", rq1[1], 32'h2222_2222);
    check("b2b_order2", rq1[2], 32'h3333_3333);

    // Reset with two requests outstanding discards them; memory survives.
    @(negedge clk);
    addr = 32'h10; req_v[1] = 1'b1;
    #1;
    check_bit("rst_mid_ok1", addr_ok_v[1], 1'b1);
    @(negedge clk);
    addr = 32'h20;
    #1;
    check_bit("rst_mid_ok2", addr_ok_v[1], 1'b1);
    @(negedge clk);
    req_v[1] = 1'b0; reset = 1'b1;
    base = dok_cnt[1];
    @(negedge clk);
    reset = 1'b0;
    repeat (8) step();
    check("rst_mid_no_data_ok", dok_cnt[1], base);
    u0_xfer("retain_u0", 1'b0, 32'h1C00_0000, 32'h0, 4'h0, 32'h1234_CC78);
    issue(1, 1'b0, 32'h30, 32'h0, 4'h0, w);
    wait_dok("retain_u1_dok", 1, base + 1);
    check("retain_u1_rdata", rq1[rq1.size() - 1], 32'h3333_3333);

    // Address delay of 2 on the third unit.
    @(negedge clk);
    wr = 1'b1; addr = 32'h40; wdata = 32'hCAFE_F00D; wstrb = 4'hF; req_v[2] = 1'b1;
    #1;
    check_bit("ad_c1", addr_ok_v[2], 1'b0);
    step();
    check_bit("ad_c2", addr_ok_v[2], 1'b0);
    step();
    check_bit("ad_c3", addr_ok_v[2], 1'b1);
    @(negedge clk);
    req_v[2] = 1'b0;
    #1;
    check_bit("ad_data_ok", data_ok_v[2], 1'b1);

    // A request dropped after one cycle is never accepted and the FSM restarts.
    @(negedge clk);
    wr = 1'b0; wstrb = 4'h0; req_v[2] = 1'b1;
    #1;
    check_bit("drop_c1", addr_ok_v[2], 1'b0);
    @(negedge clk);
    req_v[2] = 1'b0;
    #1;
    check_bit("drop_c2", addr_ok_v[2], 1'b0);
    base = dok_cnt[2];
    repeat (2) step();
    @(negedge clk);
    req_v[2] = 1'b1;
    #1;
    check_bit("restart_c1", addr_ok_v[2], 1'b0);
    step();
    check_bit("restart_c2", addr_ok_v[2], 1'b0);
    step();
    check_bit("restart_c3", addr_ok_v[2], 1'b1);
    @(negedge clk);
    req_v[2] = 1'b0;
    #1;
    check_bit("restart_data_ok", data_ok_v[2], 1'b1);
    check("restart_rdata", rdata_v[2], 32'hCAFE_F00D);
    check("drop_single_response", dok_cnt[2], base + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
